// File: rtl/sha256_digest_unloader.sv
// rtl/sha256_digest_unloader.sv - captures a SHA-256 digest and streams it out as words, H0 first
module sha256_digest_unloader #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 8,
  parameter int IDX_W     = 3
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        clear_i,
  input  logic                        digest_valid_i,
  input  logic [WORD_W*NUM_WORDS-1:0] digest_i,
  output logic                        digest_ready_o,
  output logic [WORD_W-1:0]           m_data_o,
  output logic                        m_valid_o,
  input  logic                        m_ready_i,
  output logic                        m_last_o,
  output logic [IDX_W-1:0]            word_idx_o,
  output logic                        busy_o,
  output logic                        overflow_o
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  logic [0:0]                  state;
  logic [WORD_W*NUM_WORDS-1:0] shadow;
  logic [IDX_W-1:0]            next_idx;
  logic [WORD_W-1:0]           next_word;
  logic [WORD_W-1:0]           first_word;
  logic                        capture;
  logic                        xfer;

  // Ready to take a digest whenever nothing is held
  assign digest_ready_o = (state == S_IDLE);

  // Capture and transfer qualifiers, plus the word that follows the current one
  always_comb begin
    capture    = (state == S_IDLE) && digest_valid_i && !clear_i;
    xfer       = (state == S_SEND) && m_valid_o && m_ready_i;
    next_idx   = word_idx_o + 1'b1;
    next_word  = shadow[(NUM_WORDS - 1 - int'(next_idx)) * WORD_W +: WORD_W];
    first_word = digest_i[(NUM_WORDS - 1) * WORD_W +: WORD_W];
  end

  // Shadow buffer only loads on an accepted capture so drops leave it untouched
  always_ff @(posedge CLK) begin
    if (capture) begin
      shadow <= digest_i;
    end
  end

  // Control FSM and registered stream outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= S_IDLE;
      m_data_o   <= '0;
      m_valid_o  <= 1'b0;
      m_last_o   <= 1'b0;
      word_idx_o <= '0;
      busy_o     <= 1'b0;
      overflow_o <= 1'b0;
    end else if (clear_i) begin
      state      <= S_IDLE;
      m_valid_o  <= 1'b0;
      m_last_o   <= 1'b0;
      word_idx_o <= '0;
      busy_o     <= 1'b0;
      overflow_o <= 1'b0;
    end else if (state == S_IDLE) begin
      if (capture) begin
        state      <= S_SEND;
        m_data_o   <= first_word;
        m_valid_o  <= 1'b1;
        m_last_o   <= (LAST_IDX == '0);
        word_idx_o <= '0;
        busy_o     <= 1'b1;
      end
    end else begin
      if (digest_valid_i) begin
        overflow_o <= 1'b1;
      end
      if (xfer) begin
        if (m_last_o) begin
          state      <= S_IDLE;
          m_valid_o  <= 1'b0;
          m_last_o   <= 1'b0;
          word_idx_o <= '0;
          busy_o     <= 1'b0;
        end else begin
          word_idx_o <= next_idx;
          m_data_o   <= next_word;
          m_last_o   <= (next_idx == LAST_IDX);
        end
      end
    end
  end

endmodule
